// File: rtl/mod_counter_pkg.sv
// mod_counter_pkg
//   Shared definitions for the modulo counter slice.
//   - count_mode_e : behaviour at the count bounds (wrap or saturate)
//   - params_legal : elaboration-time legality check for WIDTH/MAX/PRESCALE
package mod_counter_pkg;

    typedef enum logic {
        COUNT_WRAP = 1'b0,
        COUNT_SAT  = 1'b1
    } count_mode_e;

    // MAX must fit in WIDTH bits and be non-zero; the prescaler needs at
    // least one phase.
    function automatic bit params_legal(input int width, input int max_val,
                                        input int prescale);
        longint lim;
        if (width < 1 || max_val < 1 || prescale < 1)
            return 1'b0;
        if (width >= 62)
            return 1'b1;
        lim = (longint'(1) << width) - 1;
        return (longint'(max_val) <= lim);
    endfunction

endpackage

// File: rtl/mod_counter_prescaler.sv
// counter_prescaler
//   Clock-enable prescaler: asserts tick on every PRESCALE-th enabled cycle.
//   Ports:
//     clock  - rising-edge clock
//     reset  - synchronous, active-high; phase returns to 0
//     clear  - synchronous phase clear
//     enable - advances the phase; phase holds while low
//     tick   - enable && (phase == PRESCALE-1); equals enable for PRESCALE=1
module counter_prescaler
#(
    parameter int PRESCALE = 1
)
(
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    if (PRESCALE <= 1) begin : g_passthru
        // No phase register: the count steps on every enabled cycle.
        logic unused_inputs;
        assign unused_inputs = ^{clock, reset, clear};
        assign tick = enable;
    end else begin : g_phase
        localparam int PW = $clog2(PRESCALE);
        localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

        logic [PW-1:0] phase_q, phase_d;

        always_comb begin
            phase_d = phase_q;
            if (clear)
                phase_d = '0;
            else if (enable)
                phase_d = (phase_q == LAST) ? '0 : phase_q + 1'b1;
        end

        always_ff @(posedge clock) begin
            if (reset)
                phase_q <= '0;
            else
                phase_q <= phase_d;
        end

        // tick may be high during clear; the parent gives clear priority.
        assign tick = enable && (phase_q == LAST);
    end

endmodule

// File: rtl/mod_counter.sv
// mod_counter
//   Parametrised modulo up/down counter with wrap/saturate mode, synchronous
//   load and clear, a registered wrap pulse and an optional prescaler.
//   Ports:
//     clock      - rising-edge clock
//     reset      - synchronous, active-high
//     enable     - count enable; also advances the prescaler
//     up         - 1 = increment, 0 = decrement
//     clear      - synchronous clear of out and prescaler phase
//     load       - synchronous load of load_value (clamped to MAX)
//     load_value - value to load
//     out        - registered count, 0..MAX
//     wrap       - registered one-cycle pulse when the count wraps
//     at_max     - out == MAX (combinational)
//     at_min     - out == 0   (combinational)
module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX      = 255,
    parameter int SATURATE = 0,
    parameter int PRESCALE = 1
)
(
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             up,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] out,
    output logic             wrap,
    output logic             at_max,
    output logic             at_min
);

    if (!params_legal(WIDTH, MAX, PRESCALE)) begin : g_bad_params
        $error("mod_counter: illegal parameters WIDTH=%0d MAX=%0d PRESCALE=%0d",
               WIDTH, MAX, PRESCALE);
    end

    localparam count_mode_e      MODE  = (SATURATE != 0) ? COUNT_SAT : COUNT_WRAP;
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);

    logic             tick;
    logic [WIDTH-1:0] out_q, out_d;
    logic             wrap_q, wrap_d;

    // Load restarts the prescaler phase just like clear does.
    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clock  (clock),
        .reset  (reset),
        .clear  (clear | load),
        .enable (enable),
        .tick   (tick)
    );

    // Next-value mux: clear > load > count step.
    always_comb begin
        out_d  = out_q;
        wrap_d = 1'b0;
        if (clear) begin
            out_d = '0;
        end else if (load) begin
            out_d = (load_value > MAX_W) ? MAX_W : load_value;
        end else if (tick) begin
            if (up) begin
                if (out_q == MAX_W) begin
                    if (MODE == COUNT_WRAP) begin
                        out_d  = '0;
                        wrap_d = 1'b1;
                    end
                end else begin
                    out_d = out_q + 1'b1;
                end
            end else begin
                if (out_q == '0) begin
                    if (MODE == COUNT_WRAP) begin
                        out_d  = MAX_W;
                        wrap_d = 1'b1;
                    end
                end else begin
                    out_d = out_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            wrap_q <= wrap_d;
        end
    end

    assign out    = out_q;
    assign wrap   = wrap_q;
    assign at_max = (out_q == MAX_W);
    assign at_min = (out_q == '0);

endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter
//   Three counters (WIDTH=4, MAX=9) share one stimulus stream:
//     k=0 wrap, PRESCALE=1;  k=1 saturate, PRESCALE=1;  k=2 wrap, PRESCALE=3.
//   A behavioural model pushes expected results per step; they are popped
//   and compared one cycle later. Table vectors and hand sequences add
//   fixed expected values for the corner cases.
module tb_mod_counter;

    localparam int NDUT = 3;
    localparam int MAXV = 9;

    typedef struct {
        logic       rst;
        logic       en;
        logic       up;
        logic       clr;
        logic       ld;
        logic [3:0] lv;
    } in_t;

    typedef struct {
        in_t i;
        int  eo;
        int  ew;
    } vec_t;

    typedef struct packed {
        logic [3:0] o;
        logic       w;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       up = 1'b1;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_value = '0;

    logic [3:0] out_a  [NDUT];
    logic       wrap_a [NDUT];
    logic       amax_a [NDUT];
    logic       amin_a [NDUT];

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    int   m_out[NDUT];
    int   m_ph[NDUT];

    always #5 clock = ~clock;

    mod_counter #(.WIDTH(4), .MAX(MAXV), .SATURATE(0), .PRESCALE(1)) dut_w (
        .clock(clock), .reset(reset), .enable(enable), .up(up), .clear(clear),
        .load(load), .load_value(load_value), .out(out_a[0]), .wrap(wrap_a[0]),
        .at_max(amax_a[0]), .at_min(amin_a[0]));

    mod_counter #(.WIDTH(4), .MAX(MAXV), .SATURATE(1), .PRESCALE(1)) dut_s (
        .clock(clock), .reset(reset), .enable(enable), .up(up), .clear(clear),
        .load(load), .load_value(load_value), .out(out_a[1]), .wrap(wrap_a[1]),
        .at_max(amax_a[1]), .at_min(amin_a[1]));

    mod_counter #(.WIDTH(4), .MAX(MAXV), .SATURATE(0), .PRESCALE(3)) dut_p (
        .clock(clock), .reset(reset), .enable(enable), .up(up), .clear(clear),
        .load(load), .load_value(load_value), .out(out_a[2]), .wrap(wrap_a[2]),
        .at_max(amax_a[2]), .at_min(amin_a[2]));

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic in_t mk(input logic rst, input logic en, input logic u,
                               input logic clr, input logic ld, input int lv);
        in_t v;
        v.rst = rst; v.en = en; v.up = u; v.clr = clr; v.ld = ld; v.lv = 4'(lv);
        return v;
    endfunction

    // Reference behaviour of one counter for one clock edge.
    task automatic model(input int k, input in_t v, output exp_t e);
        bit sat;
        int pre;
        bit tk;
        sat = (k == 1);
        pre = (k == 2) ? 3 : 1;
        e.w = 1'b0;
        if (v.rst || v.clr) begin
            m_out[k] = 0;
            m_ph[k]  = 0;
        end else if (v.ld) begin
            m_out[k] = (int'(v.lv) > MAXV) ? MAXV : int'(v.lv);
            m_ph[k]  = 0;
        end else begin
            tk = v.en && (m_ph[k] == pre - 1);
            if (v.en) m_ph[k] = (m_ph[k] + 1) % pre;
            if (tk) begin
                if (v.up) begin
                    if (sat) m_out[k] = (m_out[k] < MAXV) ? m_out[k] + 1 : MAXV;
                    else begin
                        e.w = (m_out[k] == MAXV);
                        m_out[k] = (m_out[k] + 1) % (MAXV + 1);
                    end
                end else begin
                    if (sat) m_out[k] = (m_out[k] > 0) ? m_out[k] - 1 : 0;
                    else begin
                        e.w = (m_out[k] == 0);
                        m_out[k] = (m_out[k] + MAXV) % (MAXV + 1);
                    end
                end
            end
        end
        e.o = 4'(m_out[k]);
    endtask

    // Drive one cycle of stimulus, push expectations, compare after the edge.
    task automatic step(input in_t v);
        exp_t e;
        reset = v.rst; enable = v.en; up = v.up;
        clear = v.clr; load = v.ld; load_value = v.lv;
        for (int k = 0; k < NDUT; k++) begin
            model(k, v, e);
            sb.push_back(e);
        end
        @(posedge clock);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            e = sb.pop_front();
            chk($sformatf("sb_out[%0d]", k), int'(out_a[k]), int'(e.o));
            chk($sformatf("sb_wrap[%0d]", k), int'(wrap_a[k]), int'(e.w));
            chk($sformatf("sb_at_max[%0d]", k), int'(amax_a[k]), int'(e.o == 4'(MAXV)));
            chk($sformatf("sb_at_min[%0d]", k), int'(amin_a[k]), int'(e.o == 4'd0));
        end
    endtask

    vec_t tbl[$];

    initial begin
        // Expected values below are for dut_w (wrap, PRESCALE=1), from out=0.
        for (int n = 1; n <= 9; n++) tbl.push_back('{mk(0,1,1,0,0,0), n, 0});
        tbl.push_back('{mk(0,1,1,0,0,0),  0, 1});  // up wrap 9 -> 0
        tbl.push_back('{mk(0,1,1,0,0,0),  1, 0});
        tbl.push_back('{mk(0,1,1,0,1,12), 9, 0});  // load clamped, no step
        tbl.push_back('{mk(0,1,0,0,0,0),  8, 0});
        tbl.push_back('{mk(0,1,0,1,1,5),  0, 0});  // clear beats load
        tbl.push_back('{mk(0,1,0,0,0,0),  9, 1});  // down wrap 0 -> 9
        tbl.push_back('{mk(0,1,0,0,0,0),  8, 0});
        tbl.push_back('{mk(0,1,0,0,0,0),  7, 0});
        tbl.push_back('{mk(0,1,0,0,1,9),  9, 0});
        tbl.push_back('{mk(0,1,1,0,0,0),  0, 1});
        tbl.push_back('{mk(0,0,1,0,0,0),  0, 0});  // enable low: hold
        tbl.push_back('{mk(0,1,1,0,1,5),  5, 0});
        tbl.push_back('{mk(1,1,1,0,1,7),  0, 0});  // reset beats load

        m_out = '{0, 0, 0};
        m_ph  = '{0, 0, 0};

        // Reset state
        step(mk(1,0,1,0,0,0));
        step(mk(1,1,1,0,1,3));
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("reset_out[%0d]", k),    int'(out_a[k]),  0);
            chk($sformatf("reset_wrap[%0d]", k),   int'(wrap_a[k]), 0);
            chk($sformatf("reset_at_min[%0d]", k), int'(amin_a[k]), 1);
            chk($sformatf("reset_at_max[%0d]", k), int'(amax_a[k]), 0);
        end

        // Table vectors
        for (int n = 0; n < tbl.size(); n++) begin
            step(tbl[n].i);
            chk($sformatf("tbl%0d_out", n),  int'(out_a[0]),  tbl[n].eo);
            chk($sformatf("tbl%0d_wrap", n), int'(wrap_a[0]), tbl[n].ew);
        end

        // Reset mid-count
        step(mk(0,0,1,1,0,0));
        for (int n = 0; n < 5; n++) step(mk(0,1,1,0,0,0));
        chk("midrst_pre_out", int'(out_a[0]), 5);
        step(mk(1,1,1,0,0,0));
        chk("midrst_out",    int'(out_a[0]),  0);
        chk("midrst_wrap",   int'(wrap_a[0]), 0);
        chk("midrst_at_min", int'(amin_a[0]), 1);
        step(mk(0,1,1,0,0,0));
        chk("midrst_resume", int'(out_a[0]), 1);

        // Saturate on dut_s
        step(mk(0,0,1,0,1,8));
        chk("sat_load", int'(out_a[1]), 8);
        for (int n = 0; n < 4; n++) begin
            step(mk(0,1,1,0,0,0));
            chk($sformatf("sat_up%0d_out", n),  int'(out_a[1]),  9);
            chk($sformatf("sat_up%0d_wrap", n), int'(wrap_a[1]), 0);
        end
        step(mk(0,1,0,0,0,0));
        chk("sat_down_out", int'(out_a[1]), 8);
        step(mk(0,0,0,1,0,0));
        step(mk(0,1,0,0,0,0));
        chk("sat_floor_out",  int'(out_a[1]),  0);
        chk("sat_floor_wrap", int'(wrap_a[1]), 0);

        // Prescaler on dut_p: after clear, ticks on every 3rd enabled edge
        step(mk(0,0,1,1,0,0));
        begin
            int exp_pre[7] = '{0, 0, 1, 1, 1, 2, 2};
            for (int n = 0; n < 7; n++) begin
                step(mk(0,1,1,0,0,0));
                chk($sformatf("pre_run%0d", n), int'(out_a[2]), exp_pre[n]);
            end
        end
        step(mk(0,0,1,0,0,0));
        step(mk(0,0,1,0,0,0));
        chk("pre_frozen", int'(out_a[2]), 2);
        step(mk(0,1,1,0,0,0));
        chk("pre_reen1", int'(out_a[2]), 2);
        step(mk(0,1,1,0,0,0));
        chk("pre_reen2", int'(out_a[2]), 3);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            step(mk($urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 2) != 0, $urandom_range(0, 30) == 0,
                    $urandom_range(0, 15) == 0, int'($urandom_range(0, 15))));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
